apb_mem_completer: RTL and testbench

//  APB4 completer front-end: converts APB4 transfers into a valid/ready memory request plus a response channel.
//  It is the inverse of the master, which turns simple S* requests into APB.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_access_checker.sv | 41 ++++
 rtl/apb_mem_completer.sv | 169 ++++++++++++++++
 tb/tb_apb_mem_completer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB memory completer: FSM states, error causes and default bus widths.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE,
        DRAIN
    } completer_state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_ALIGN,
        ERR_STRB,
        ERR_PROT,
        ERR_BACKEND,
        ERR_TIMEOUT
    } slverr_cause_e;

endpackage

// File: rtl/apb_access_checker.sv
// Combinational access filter: decodes the memory window and flags range, alignment,
// read-strobe and privilege violations, reporting the first one found.
module apb_access_checker
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int                    STRB_WIDTH = APB_DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter int unsigned           MEM_SIZE   = 4096,
    parameter bit                    PRIV_ONLY  = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    input  logic [STRB_WIDTH-1:0] strb,
    input  logic                  prot_priv,
    output logic [ADDR_WIDTH-1:0] offset,
    output slverr_cause_e         cause
);

    // One extra bit so an address below MEM_BASE wraps to a value past the window.
    logic [ADDR_WIDTH:0] offset_wide;
    logic                in_range;

    assign offset_wide = {1'b0, addr} - {1'b0, MEM_BASE};
    assign in_range    = offset_wide < (ADDR_WIDTH + 1)'(MEM_SIZE);
    assign offset      = offset_wide[ADDR_WIDTH-1:0];

    always_comb begin
        cause = ERR_NONE;
        if (!in_range) begin
            cause = ERR_RANGE;
        end else if (addr[1:0] != 2'b00) begin
            cause = ERR_ALIGN;
        end else if (!write && (strb != '0)) begin
            cause = ERR_STRB;
        end else if (PRIV_ONLY && !prot_priv) begin
            cause = ERR_PROT;
        end
    end

endmodule

// File: rtl/apb_mem_completer.sv
// APB4 completer that turns bus transfers into a valid/ready backend request and waits for a
// one-cycle response, with access checking, PSLVERR generation and a backend timeout.
module apb_mem_completer
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = APB_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = '0,
    parameter int unsigned           MEM_SIZE       = 4096,
    parameter bit                    PRIV_ONLY      = 1'b0,
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_write,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic                    rsp_valid,
    input  logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    rsp_err
);

    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    localparam int          CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    completer_state_e        state, state_n;
    slverr_cause_e           cause_q, cause_n, chk_cause;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    drain_q, drain_n;
    logic                    pend_q, pend_n;
    logic [DATA_WIDTH-1:0]   rdata_n;
    logic [ADDR_WIDTH-1:0]   chk_offset;
    logic                    capture;
    logic                    setup;
    logic                    timeout_hit;
    logic                    unused_prot;

    assign setup       = PSEL && !PENABLE;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));
    assign unused_prot = ^PPROT[2:1];

    apb_access_checker #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .STRB_WIDTH(STRB_WIDTH),
        .MEM_BASE  (MEM_BASE),
        .MEM_SIZE  (MEM_SIZE),
        .PRIV_ONLY (PRIV_ONLY)
    ) u_checker (
        .addr     (PADDR),
        .write    (PWRITE),
        .strb     (PSTRB),
        .prot_priv(PPROT[0]),
        .offset   (chk_offset),
        .cause    (chk_cause)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cause_q   <= ERR_NONE;
            cnt       <= '0;
            drain_q   <= 1'b0;
            pend_q    <= 1'b0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
        end else begin
            state     <= state_n;
            cause_q   <= cause_n;
            cnt       <= cnt_n;
            drain_q   <= drain_n;
            pend_q    <= pend_n;
            // Bus-facing outputs are registered from the next state so they are glitch-free.
            PREADY    <= (state_n == DONE);
            PSLVERR   <= (state_n == DONE) && (cause_n != ERR_NONE);
            PRDATA    <= ((state_n == DONE) && (cause_n == ERR_NONE)) ? rdata_n : '0;
            req_valid <= (state_n == REQ);
            if (capture) begin
                req_write <= PWRITE;
                req_addr  <= chk_offset;
                req_wdata <= PWDATA;
                req_strb  <= PSTRB;
            end
        end
    end

    always_comb begin
        state_n = state;
        cause_n = cause_q;
        cnt_n   = '0;
        drain_n = drain_q;
        pend_n  = pend_q;
        rdata_n = '0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    capture = 1'b1;
                    cause_n = chk_cause;
                    state_n = (chk_cause == ERR_NONE) ? REQ : DONE;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    state_n = DONE;
                    cause_n = ERR_TIMEOUT;
                    drain_n = req_ready;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (req_ready) state_n = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    state_n = DONE;
                    cause_n = rsp_err ? ERR_BACKEND : ERR_NONE;
                    rdata_n = req_write ? '0 : rsp_rdata;
                end else if (timeout_hit) begin
                    state_n = DONE;
                    cause_n = ERR_TIMEOUT;
                    drain_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = drain_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                // A setup phase arriving here is parked until the stale response is swallowed.
                if (setup && !pend_q) begin
                    capture = 1'b1;
                    cause_n = chk_cause;
                    pend_n  = 1'b1;
                end
                if (rsp_valid) begin
                    drain_n = 1'b0;
                    pend_n  = 1'b0;
                    if (pend_q || setup) begin
                        state_n = (cause_n == ERR_NONE) ? REQ : DONE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer: drives APB transfers and a scripted backend, checking
// latency, payload, PRDATA/PSLVERR, timeout/drain and reset behaviour against hand-derived values.
module tb_apb_mem_completer;
    import apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;
    logic [31:0] PRDATA;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 PCLK = ~PCLK;

    apb_mem_completer #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MEM_BASE      (32'h0000_0000),
        .MEM_SIZE      (4096),
        .PRIV_ONLY     (1'b1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int total = 0;
    int passes = 0;

    int          r_cyc, r_first;
    logic        r_saw, r_err, r_wr;
    logic [31:0] r_data, r_addr, r_wdata;
    logic [3:0]  r_strb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    // One APB transfer with a scripted backend: accept after 'stall' cycles of req_valid,
    // respond 'lat' cycles after acceptance (0 = never), optional stray response at 'late_at'.
    task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int stall,
                        input int lat, input logic rerr, input logic [31:0] rdata,
                        input int late_at);
        int  acc;
        int  st;
        bit  done;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; PPROT = prot;
        @(negedge PCLK);
        PENABLE = 1'b1;
        r_cyc = 0; r_first = 0; r_saw = 1'b0; acc = 0; st = 0; done = 1'b0;
        r_addr = '0; r_wdata = '0; r_strb = '0; r_wr = 1'b0;
        while (!done) begin
            r_cyc++;
            req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
            if (req_valid) begin
                if (!r_saw) r_first = r_cyc;
                r_saw = 1'b1;
                if (acc == 0) begin
                    if (st == stall) begin
                        req_ready = 1'b1;
                        acc       = r_cyc;
                        r_addr    = req_addr;
                        r_wdata   = req_wdata;
                        r_strb    = req_strb;
                        r_wr      = req_write;
                    end else begin
                        st++;
                    end
                end
            end
            if (acc > 0 && lat > 0 && r_cyc == acc + lat) begin
                rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = rerr;
            end
            if (late_at > 0 && r_cyc == late_at) begin
                rsp_valid = 1'b1; rsp_rdata = 32'hBAD0_BAD0; rsp_err = 1'b1;
            end
            if (PREADY) begin
                done = 1'b1; r_data = PRDATA; r_err = PSLVERR;
            end else if (r_cyc >= 40) begin
                check("pready_bound", {31'b0, PREADY}, 32'd1);
                done = 1'b1; r_data = PRDATA; r_err = PSLVERR;
            end else begin
                @(negedge PCLK);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
        repeat (3) @(negedge PCLK);
        check("rst_pready", {31'b0, PREADY}, 32'd0);
        check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
        check("rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        PRESET = 1'b0;

        // Plain write, zero-stall backend
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("wr_latency", 32'(r_cyc), 32'd3);
        check("wr_slverr", {31'b0, r_err}, 32'd0);
        check("wr_req_addr", r_addr, 32'h10);
        check("wr_req_strb", {28'b0, r_strb}, 32'hF);
        check("wr_req_wdata", r_wdata, 32'hDEAD_BEEF);
        check("wr_req_write", {31'b0, r_wr}, 32'd1);
        check("wr_prdata", r_data, 32'd0);
        idle();

        // Read with two cycles of req_ready stall, then back-to-back read with backend error
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, 2, 1, 1'b0, 32'hDEAD_BEEF, 0);
        check("rd_stall_latency", 32'(r_cyc), 32'd5);
        check("rd_stall_prdata", r_data, 32'hDEAD_BEEF);
        check("rd_stall_slverr", {31'b0, r_err}, 32'd0);
        check("rd_stall_first_valid", 32'(r_first), 32'd1);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b001, 0, 1, 1'b1, 32'h1234_5678, 0);
        check("b2b_beerr_latency", 32'(r_cyc), 32'd3);
        check("b2b_beerr_slverr", {31'b0, r_err}, 32'd1);
        check("b2b_beerr_prdata", r_data, 32'd0);
        idle();

        // Checker rejections complete with zero wait states and no backend request
        xfer(1'b0, 32'h1000, 32'h0, 4'h0, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("range_latency", 32'(r_cyc), 32'd1);
        check("range_slverr", {31'b0, r_err}, 32'd1);
        check("range_no_req", {31'b0, r_saw}, 32'd0);
        xfer(1'b1, 32'h3, 32'h55, 4'hF, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("align_latency", 32'(r_cyc), 32'd1);
        check("align_slverr", {31'b0, r_err}, 32'd1);
        check("align_no_req", {31'b0, r_saw}, 32'd0);
        xfer(1'b1, 32'h40, 32'h66, 4'hF, 3'b000, 0, 1, 1'b0, 32'h0, 0);
        check("prot_slverr", {31'b0, r_err}, 32'd1);
        check("prot_no_req", {31'b0, r_saw}, 32'd0);
        xfer(1'b1, 32'h40, 32'h66, 4'hF, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("priv_ok_latency", 32'(r_cyc), 32'd3);
        check("priv_ok_slverr", {31'b0, r_err}, 32'd0);
        xfer(1'b0, 32'h40, 32'h0, 4'h1, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("rdstrb_latency", 32'(r_cyc), 32'd1);
        check("rdstrb_slverr", {31'b0, r_err}, 32'd1);
        xfer(1'b0, 32'hFFC, 32'h0, 4'h0, 3'b001, 0, 1, 1'b0, 32'h0BAD_F00D, 0);
        check("top_word_addr", r_addr, 32'hFFC);
        check("top_word_prdata", r_data, 32'h0BAD_F00D);
        idle();

        // Timeout after acceptance, then next transfer waits for the stale response
        xfer(1'b0, 32'h80, 32'h0, 4'h0, 3'b001, 0, 0, 1'b0, 32'h0, 0);
        check("to_wait_latency", 32'(r_cyc), 32'd5);
        check("to_wait_slverr", {31'b0, r_err}, 32'd1);
        check("to_wait_prdata", r_data, 32'd0);
        xfer(1'b0, 32'h84, 32'h0, 4'h0, 3'b001, 0, 1, 1'b0, 32'hCAFE_F00D, 2);
        check("drain_latency", 32'(r_cyc), 32'd5);
        check("drain_first_valid", 32'(r_first), 32'd3);
        check("drain_prdata", r_data, 32'hCAFE_F00D);
        check("drain_slverr", {31'b0, r_err}, 32'd0);
        idle();

        // Timeout while never accepted: no drain afterwards
        xfer(1'b1, 32'h88, 32'h77, 4'hF, 3'b001, 100, 1, 1'b0, 32'h0, 0);
        check("to_req_latency", 32'(r_cyc), 32'd5);
        check("to_req_slverr", {31'b0, r_err}, 32'd1);
        xfer(1'b1, 32'h8, 32'h99, 4'h3, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("after_to_req_latency", 32'(r_cyc), 32'd3);
        check("after_to_req_strb", {28'b0, r_strb}, 32'h3);
        idle();

        // Reset asserted while waiting for a response
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h100;
        PWDATA = 32'h1111_2222; PSTRB = 4'hF; PPROT = 3'b001;
        @(negedge PCLK);
        PENABLE = 1'b1; req_ready = 1'b1;
        @(negedge PCLK);
        req_ready = 1'b0;
        check("pre_rst_req_addr", req_addr, 32'h100);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("mid_rst_pready", {31'b0, PREADY}, 32'd0);
        check("mid_rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("mid_rst_req_addr", req_addr, 32'd0);
        check("mid_rst_req_wdata", req_wdata, 32'd0);
        check("mid_rst_req_write", {31'b0, req_write}, 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        xfer(1'b1, 32'h104, 32'h3333_4444, 4'hF, 3'b001, 0, 1, 1'b0, 32'h0, 0);
        check("post_rst_latency", 32'(r_cyc), 32'd3);
        check("post_rst_slverr", {31'b0, r_err}, 32'd0);
        check("post_rst_req_addr", r_addr, 32'h104);
        idle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
